// File: rtl/sampler.sv
// ----------------------------------------------------------------------------
// sampler
//   Decimates the synchronized probe word by a programmable divider and emits
//   one registered sample plus a one-cycle strobe per sample period. Byte
//   groups flagged in grp_dis_i are zeroed in the captured word.
//
//   Ports:
//     clk_i      system clock
//     rst_in     asynchronous active-low reset
//     en_i       run enable (level)
//     div_i      divider value N, sample period = N+1 clocks
//     div_we_i   load div_i into the divider register
//     grp_dis_i  per-byte group disable, bit g zeroes bits [8g+7:8g]
//     data_i     synchronized probe word
//     smpl_o     registered sample word
//     stb_o      one-cycle strobe, smpl_o valid in the same cycle
// ----------------------------------------------------------------------------

// Per-byte mask lane: passes the byte through unless its group is disabled.
module sampler_lane (
    input  logic [7:0] din,
    input  logic       dis,
    output logic [7:0] dout
);
    assign dout = dis ? 8'h00 : din;
endmodule

module sampler #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 24
) (
    input  logic               clk_i,
    input  logic               rst_in,
    input  logic               en_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic               div_we_i,
    input  logic [WIDTH/8-1:0] grp_dis_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic [WIDTH-1:0]   smpl_o,
    output logic               stb_o
);
    localparam int NUM_GRP = WIDTH / 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state;
    logic [DIV_W-1:0]           div_q;
    logic [DIV_W-1:0]           cnt;
    logic [DIV_W-1:0]           reload;
    logic [NUM_GRP-1:0][7:0]    data_g;
    logic [NUM_GRP-1:0][7:0]    masked_g;

    assign data_g = data_i;

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_lane
        sampler_lane u_lane (
            .din  (data_g[g]),
            .dis  (grp_dis_i[g]),
            .dout (masked_g[g])
        );
    end

    // A divider write on the reload edge takes effect immediately.
    assign reload = div_we_i ? div_i : div_q;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state  <= IDLE;
            div_q  <= '0;
            cnt    <= '0;
            smpl_o <= '0;
            stb_o  <= 1'b0;
        end else begin
            if (div_we_i)
                div_q <= div_i;

            case (state)
                IDLE: begin
                    // cnt parked at 0 so the first RUN edge captures.
                    stb_o <= 1'b0;
                    cnt   <= '0;
                    if (en_i)
                        state <= RUN;
                end
                RUN: begin
                    if (!en_i) begin
                        // Stop wins over a due capture; phase is discarded.
                        state <= IDLE;
                        stb_o <= 1'b0;
                    end else if (cnt == '0) begin
                        stb_o  <= 1'b1;
                        smpl_o <= masked_g;
                        cnt    <= reload;
                    end else begin
                        stb_o <= 1'b0;
                        cnt   <= cnt - DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    stb_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sampler.sv
module tb_sampler;
    localparam int WIDTH = 32;
    localparam int DIV_W = 24;
    localparam int NG    = WIDTH / 8;

    logic             clk_i = 1'b0;
    logic             rst_in = 1'b0;
    logic             en_i = 1'b0;
    logic [DIV_W-1:0] div_i = '0;
    logic             div_we_i = 1'b0;
    logic [NG-1:0]    grp_dis_i = '0;
    logic [WIDTH-1:0] data_i = '0;
    logic [WIDTH-1:0] smpl_o;
    logic             stb_o;

    int n_vec = 0;
    int n_err = 0;

    sampler #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .en_i      (en_i),
        .div_i     (div_i),
        .div_we_i  (div_we_i),
        .grp_dis_i (grp_dis_i),
        .data_i    (data_i),
        .smpl_o    (smpl_o),
        .stb_o     (stb_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: absolute edge scheduling, next strobe edge number.
    longint           t = 0;
    longint           m_next = 0;
    bit               m_run = 0;
    logic [DIV_W-1:0] m_div = '0;
    logic [WIDTH-1:0] m_smpl = '0;
    logic             m_stb = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] masked(input logic [WIDTH-1:0] d, input logic [NG-1:0] dis);
        logic [WIDTH-1:0] r = d;
        for (int g = 0; g < NG; g++)
            if (dis[g]) r[g*8 +: 8] = 8'h00;
        return r;
    endfunction

    task automatic model_reset();
        m_run = 0; m_stb = 1'b0; m_smpl = '0; m_div = '0;
    endtask

    task automatic model_edge();
        logic [DIV_W-1:0] nd;
        nd = div_we_i ? div_i : m_div;
        if (!m_run) begin
            m_stb = 1'b0;
            if (en_i) begin m_run = 1; m_next = t + 1; end
        end else if (!en_i) begin
            m_run = 0; m_stb = 1'b0;
        end else if (t == m_next) begin
            m_stb  = 1'b1;
            m_smpl = masked(data_i, grp_dis_i);
            m_next = t + longint'(nd) + 1;
        end else begin
            m_stb = 1'b0;
        end
        if (div_we_i) m_div = div_i;
        t++;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("stb", {63'd0, stb_o}, {63'd0, m_stb});
        chk("smpl", {32'd0, smpl_o}, {32'd0, m_smpl});
    endtask

    task automatic load_div(input int n);
        div_i = DIV_W'(n); div_we_i = 1'b1;
        step();
        div_we_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_stb", {63'd0, stb_o}, 64'd0);
        chk("rst_smpl", {32'd0, smpl_o}, 64'd0);
        @(negedge clk_i);
        rst_in = 1'b1;
        step();

        // Group mask at full rate
        data_i = 32'hA5A5_A5A5; grp_dis_i = 4'b0101;
        load_div(0);
        en_i = 1'b1;
        step();
        chk("start_nostb", {63'd0, stb_o}, 64'd0);
        step();
        chk("mask_stb", {63'd0, stb_o}, 64'd1);
        chk("mask_val", {32'd0, smpl_o}, 64'h0000_0000_A500_A500);
        grp_dis_i = '0;
        for (int i = 0; i < 6; i++) begin
            data_i = $urandom;
            step();
            chk("full_rate", {63'd0, stb_o}, 64'd1);
        end

        // Asynchronous reset mid-cycle while running at N=0
        #3;
        rst_in = 1'b0;
        #1;
        chk("async_stb", {63'd0, stb_o}, 64'd0);
        chk("async_smpl", {32'd0, smpl_o}, 64'd0);
        model_reset();
        en_i = 1'b0;
        @(negedge clk_i);
        rst_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_nostb", {63'd0, stb_o}, 64'd0);
        end

        // Decimation N=3, incrementing data
        load_div(3);
        en_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            data_i = 32'(100 + i);
            step();
            chk("dec_stb", {63'd0, stb_o}, {63'd0, (i == 1 || i == 5 || i == 9)});
            if (i == 1 || i == 5 || i == 9)
                chk("dec_val", {32'd0, smpl_o}, 64'(100 + i));
        end

        // Divider change mid-count: N=7, write 1 two cycles after a strobe
        en_i = 1'b0; step();
        load_div(7);
        en_i = 1'b1;
        step(); step();
        chk("n7_first", {63'd0, stb_o}, 64'd1);
        step(); step();
        div_i = DIV_W'(1); div_we_i = 1'b1;
        step();
        div_we_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            data_i = $urandom;
            step();
        end

        // Write coinciding with the reload edge (N=0 running -> write 4)
        load_div(0);
        step();
        div_i = DIV_W'(4); div_we_i = 1'b1;
        step();
        div_we_i = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Stop on strobe, N=2
        en_i = 1'b0; step();
        load_div(2);
        en_i = 1'b1;
        step(); step(); step(); step();
        en_i = 1'b0;
        step();
        chk("stop_nostb", {63'd0, stb_o}, 64'd0);
        en_i = 1'b1;
        step();
        chk("restart_nostb", {63'd0, stb_o}, 64'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("restart_stb", {63'd0, stb_o}, {63'd0, (i % 3 == 0)});
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            data_i    = $urandom;
            grp_dis_i = NG'($urandom);
            if ($urandom_range(0, 19) == 0) en_i = ~en_i;
            div_we_i  = ($urandom_range(0, 9) == 0);
            div_i     = DIV_W'($urandom_range(0, 6));
            step();
        end
        div_we_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
